// File: rtl/ucca_cfg_pkg.sv
// Shared definitions for the UCCA configuration controller: FSM encoding,
// register offsets, STATUS bit positions and metadata window defaults.
package ucca_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OVL     = 3'd2,
    ST_PUBLISH = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  // Word offset of CTRL/STATUS; MIN[i] sits at 2i+1 and MAX[i] at 2i+2.
  localparam logic [13:0] OFF_CTRL = 14'd0;

  localparam int STAT_LOCKED      = 0;
  localparam int STAT_ERROR       = 1;
  localparam int STAT_BUSY        = 2;
  localparam int STAT_ERR_IDX_LSB = 4;
  localparam int STAT_ERR_KIND    = 8;

  localparam logic [15:0] META_MIN_DEF = 16'h0140;
  localparam logic [15:0] META_MAX_DEF = 16'h016A;

  // Two inclusive ranges share at least one address.
  function automatic logic ranges_overlap(input logic [15:0] a_min, input logic [15:0] a_max,
                                          input logic [15:0] b_min, input logic [15:0] b_max);
    return (a_min <= b_max) && (b_min <= a_max);
  endfunction

endpackage

// File: rtl/ucca_cfg_ctrl_bound_check.sv
// Combinational single-region validator: flags an odd lower bound, an empty
// or inverted range, or any contact with the protected metadata window.
module ucca_bound_check
  import ucca_cfg_pkg::*;
#(
  parameter logic [15:0] META_MIN = META_MIN_DEF,
  parameter logic [15:0] META_MAX = META_MAX_DEF
) (
  input  logic [15:0] reg_min,
  input  logic [15:0] reg_max,
  output logic        fail
);

  // Any one rule violated rejects the region.
  always_comb begin
    fail = reg_min[0]
         | (reg_min >= reg_max)
         | ranges_overlap(reg_min, reg_max, META_MIN, META_MAX);
  end

endmodule

// File: rtl/ucca_cfg_ctrl.sv
// UCCA configuration controller. Software stages per-region bounds over the
// peripheral bus and commits; a sequencer validates them and, on success,
// publishes and locks them until power-on reset.
// Optional pairwise overlap check: define UCCA_OVERLAP_CHECK_EN.
//
// Bus handshake: a write is per_en with any per_we bit set and lands on the
// next clk edge; a read is per_en with per_we == 0 and per_dout is valid in
// the same cycle. There is no back-pressure; writes outside IDLE are dropped.
module ucca_cfg_ctrl
  import ucca_cfg_pkg::*;
#(
  parameter int          NUM_REGIONS = 3,
  parameter logic [13:0] BASE_ADDR   = 14'h0060,
  parameter logic [15:0] META_MIN    = META_MIN_DEF,
  parameter logic [15:0] META_MAX    = META_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      per_en,
  input  logic [1:0]                per_we,
  input  logic [13:0]               per_addr,
  input  logic [15:0]               per_din,
  output logic [15:0]               per_dout,
  input  logic                      hw_reset,
  output logic [16*NUM_REGIONS-1:0] ucc_min_flat,
  output logic [16*NUM_REGIONS-1:0] ucc_max_flat,
  output logic                      cfg_valid,
  output logic                      lock_viol,
  output state_t                    dbg_state
);

  localparam logic [13:0] LAST_OFF = 14'(2 * NUM_REGIONS);
  localparam logic [2:0]  LAST_IDX = 3'(NUM_REGIONS - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic [2:0]  err_idx_q, err_idx_d;
  logic        err_kind_q, err_kind_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        lock_viol_q, lock_viol_d;
  logic [15:0] min_q [NUM_REGIONS];
  logic [15:0] min_d [NUM_REGIONS];
  logic [15:0] max_q [NUM_REGIONS];
  logic [15:0] max_d [NUM_REGIONS];
  logic [15:0] pub_min_q [NUM_REGIONS];
  logic [15:0] pub_min_d [NUM_REGIONS];
  logic [15:0] pub_max_q [NUM_REGIONS];
  logic [15:0] pub_max_d [NUM_REGIONS];

`ifdef UCCA_OVERLAP_CHECK_EN
  logic [2:0]  pi_q, pi_d;
  logic [2:0]  pj_q, pj_d;
  logic [15:0] pa_min, pa_max, pb_min, pb_max;
  logic        pair_hit;
`endif

  logic [13:0] off;
  logic        hit;
  logic        wr;
  logic        busy;
  logic [15:0] status;
  logic [15:0] chk_min, chk_max;
  logic        chk_fail;

  assign off  = per_addr - BASE_ADDR;
  assign hit  = per_en && (per_addr >= BASE_ADDR) && (off <= LAST_OFF);
  assign wr   = hit && (per_we != 2'b00);
  assign busy = (state_q == ST_CHECK) || (state_q == ST_OVL) || (state_q == ST_PUBLISH);

  // STATUS word assembled from live state and error flops.
  always_comb begin
    status = '0;
    status[STAT_LOCKED]                = (state_q == ST_LOCKED);
    status[STAT_ERROR]                 = err_q;
    status[STAT_BUSY]                  = busy;
    status[STAT_ERR_IDX_LSB +: 3]      = err_idx_q;
    status[STAT_ERR_KIND]              = err_kind_q;
  end

  // Combinational read mux; zero unless this block is addressed by a read.
  always_comb begin
    per_dout = '0;
    if (hit && (per_we == 2'b00)) begin
      if (off == OFF_CTRL) per_dout = status;
      for (int k = 0; k < NUM_REGIONS; k++) begin
        if (off == 14'(2 * k + 1)) per_dout = min_q[k];
        if (off == 14'(2 * k + 2)) per_dout = max_q[k];
      end
    end
  end

  // Select the region under test by idx for the shared validator.
  always_comb begin
    chk_min = min_q[0];
    chk_max = max_q[0];
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (idx_q == 3'(k)) begin
        chk_min = min_q[k];
        chk_max = max_q[k];
      end
    end
  end

  ucca_bound_check #(
    .META_MIN (META_MIN),
    .META_MAX (META_MAX)
  ) u_bound_check (
    .reg_min (chk_min),
    .reg_max (chk_max),
    .fail    (chk_fail)
  );

`ifdef UCCA_OVERLAP_CHECK_EN
  // Select the current (i, j) pair and test it for overlap.
  always_comb begin
    pa_min = min_q[0];
    pa_max = max_q[0];
    pb_min = min_q[0];
    pb_max = max_q[0];
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (pi_q == 3'(k)) begin
        pa_min = min_q[k];
        pa_max = max_q[k];
      end
      if (pj_q == 3'(k)) begin
        pb_min = min_q[k];
        pb_max = max_q[k];
      end
    end
    pair_hit = ranges_overlap(pa_min, pa_max, pb_min, pb_max);
  end
`endif

  // Next-state logic for the sequencer, staging, error and output registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    err_kind_d  = err_kind_q;
    cfg_valid_d = cfg_valid_q;
    lock_viol_d = 1'b0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      min_d[k]     = min_q[k];
      max_d[k]     = max_q[k];
      pub_min_d[k] = pub_min_q[k];
      pub_max_d[k] = pub_max_q[k];
    end
`ifdef UCCA_OVERLAP_CHECK_EN
    pi_d = pi_q;
    pj_d = pj_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr) begin
          if (off == OFF_CTRL) begin
            if (per_din[0]) begin
              state_d    = ST_CHECK;
              idx_d      = 3'd0;
              err_d      = 1'b0;
              err_idx_d  = 3'd0;
              err_kind_d = 1'b0;
            end
          end else begin
            for (int k = 0; k < NUM_REGIONS; k++) begin
              if (off == 14'(2 * k + 1)) min_d[k] = per_din;
              if (off == 14'(2 * k + 2)) max_d[k] = per_din;
            end
          end
        end
      end
      ST_CHECK: begin
        if (hw_reset) begin
          state_d = ST_IDLE;
        end else if (chk_fail) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_idx_d  = idx_q;
          err_kind_d = 1'b0;
        end else if (idx_q == LAST_IDX) begin
`ifdef UCCA_OVERLAP_CHECK_EN
          if (NUM_REGIONS > 1) begin
            state_d = ST_OVL;
            pi_d    = 3'd0;
            pj_d    = 3'd1;
          end else begin
            state_d = ST_PUBLISH;
          end
`else
          state_d = ST_PUBLISH;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef UCCA_OVERLAP_CHECK_EN
      ST_OVL: begin
        if (hw_reset) begin
          state_d = ST_IDLE;
        end else if (pair_hit) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_idx_d  = pi_q;
          err_kind_d = 1'b1;
        end else if (pj_q == LAST_IDX) begin
          if (pi_q == 3'(NUM_REGIONS - 2)) begin
            state_d = ST_PUBLISH;
          end else begin
            pi_d = pi_q + 3'd1;
            pj_d = pi_q + 3'd2;
          end
        end else begin
          pj_d = pj_q + 3'd1;
        end
      end
`endif
      ST_PUBLISH: begin
        if (hw_reset) begin
          state_d = ST_IDLE;
        end else begin
          for (int k = 0; k < NUM_REGIONS; k++) begin
            pub_min_d[k] = min_q[k];
            pub_max_d[k] = max_q[k];
          end
          cfg_valid_d = 1'b1;
          state_d     = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        lock_viol_d = wr;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      err_q       <= 1'b0;
      err_idx_q   <= 3'd0;
      err_kind_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      lock_viol_q <= 1'b0;
      for (int k = 0; k < NUM_REGIONS; k++) begin
        min_q[k]     <= '0;
        max_q[k]     <= '0;
        pub_min_q[k] <= '0;
        pub_max_q[k] <= '0;
      end
`ifdef UCCA_OVERLAP_CHECK_EN
      pi_q <= 3'd0;
      pj_q <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
      err_kind_q  <= err_kind_d;
      cfg_valid_q <= cfg_valid_d;
      lock_viol_q <= lock_viol_d;
      for (int k = 0; k < NUM_REGIONS; k++) begin
        min_q[k]     <= min_d[k];
        max_q[k]     <= max_d[k];
        pub_min_q[k] <= pub_min_d[k];
        pub_max_q[k] <= pub_max_d[k];
      end
`ifdef UCCA_OVERLAP_CHECK_EN
      pi_q <= pi_d;
      pj_q <= pj_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_flat
    assign ucc_min_flat[16*g +: 16] = pub_min_q[g];
    assign ucc_max_flat[16*g +: 16] = pub_max_q[g];
  end

  assign cfg_valid = cfg_valid_q;
  assign lock_viol = lock_viol_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ucca_cfg_ctrl.sv
// Self-checking bench for ucca_cfg_ctrl (NUM_REGIONS = 3): directed vector
// table, hand-written multi-cycle sequences, and randomized commits checked
// against a rule-level reference model.
module tb_ucca_cfg_ctrl;
  import ucca_cfg_pkg::*;

  localparam int          N        = 3;
  localparam logic [13:0] BASE     = 14'h0060;
  localparam logic [15:0] META_MIN = 16'h0140;
  localparam logic [15:0] META_MAX = 16'h016A;
`ifdef UCCA_OVERLAP_CHECK_EN
  localparam int LAT_OK = 7;
`else
  localparam int LAT_OK = 4;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          per_en = 1'b0;
  logic [1:0]    per_we = 2'b00;
  logic [13:0]   per_addr = '0;
  logic [15:0]   per_din = '0;
  logic [15:0]   per_dout;
  logic          hw_reset = 1'b0;
  logic [47:0]   ucc_min_flat;
  logic [47:0]   ucc_max_flat;
  logic          cfg_valid;
  logic          lock_viol;
  state_t        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mdl_min [N];
  logic [15:0] mdl_max [N];

  typedef struct packed {
    logic [2:0][15:0] mn;
    logic [2:0][15:0] mx;
    logic [15:0]      exp_status;
    logic [7:0]       exp_cyc;
  } vec_t;

  vec_t tbl [9];

  ucca_cfg_ctrl #(.NUM_REGIONS(N), .BASE_ADDR(BASE), .META_MIN(META_MIN), .META_MAX(META_MAX)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .per_en       (per_en),
    .per_we       (per_we),
    .per_addr     (per_addr),
    .per_din      (per_din),
    .per_dout     (per_dout),
    .hw_reset     (hw_reset),
    .ucc_min_flat (ucc_min_flat),
    .ucc_max_flat (ucc_max_flat),
    .cfg_valid    (cfg_valid),
    .lock_viol    (lock_viol),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    per_en = 1'b0; per_we = 2'b00; per_din = '0; hw_reset = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      mdl_min[k] = '0;
      mdl_max[k] = '0;
    end
  endtask

  task automatic bus_write(input logic [13:0] o, input logic [15:0] d);
    @(negedge clk);
    per_en = 1'b1; per_we = 2'b11; per_addr = BASE + o; per_din = d;
    @(posedge clk);
    #1;
    per_en = 1'b0; per_we = 2'b00; per_din = '0;
  endtask

  task automatic bus_read(input logic [13:0] o, output logic [15:0] d);
    per_en = 1'b1; per_we = 2'b00; per_addr = BASE + o;
    #1 d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic program_regions(input logic [2:0][15:0] mn, input logic [2:0][15:0] mx);
    for (int k = 0; k < N; k++) begin
      bus_write(14'(2 * k + 1), mn[k]);
      bus_write(14'(2 * k + 2), mx[k]);
      mdl_min[k] = mn[k];
      mdl_max[k] = mx[k];
    end
  endtask

  // Hold a STATUS read and count edges until BUSY drops (bounded).
  task automatic wait_done(output int cyc, output logic [15:0] st);
    bit done;
    done = 1'b0;
    cyc = 0;
    per_en = 1'b1; per_we = 2'b00; per_addr = BASE;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      if (per_dout[2] == 1'b0) done = 1'b1;
    end
    st = per_dout;
    per_en = 1'b0;
    check("done_within_budget", {47'd0, done}, 48'd1);
  endtask

  task automatic run_commit(output int cyc, output logic [15:0] st);
    bus_write(OFF_CTRL, 16'h0001);
    wait_done(cyc, st);
  endtask

  // Reference model: apply the validation rules region by region, then pair by pair.
  function automatic void predict(output bit ok, output int e_idx, output int e_kind, output int cyc);
    int p;
    ok = 1'b1; e_idx = 0; e_kind = 0; p = 0;
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      if (ok) begin
        if (mdl_min[k][0] || (mdl_min[k] >= mdl_max[k]) ||
            ((mdl_min[k] <= META_MAX) && (mdl_max[k] >= META_MIN))) begin
          ok = 1'b0; e_idx = k; cyc = k + 1;
        end
      end
    end
`ifdef UCCA_OVERLAP_CHECK_EN
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (ok) begin
          p++;
          if ((mdl_min[i] <= mdl_max[j]) && (mdl_min[j] <= mdl_max[i])) begin
            ok = 1'b0; e_idx = i; e_kind = 1; cyc = N + p;
          end
        end
      end
    end
    if (ok) cyc = N + (N * (N - 1)) / 2 + 1;
`else
    if (ok) cyc = N + 1;
`endif
  endfunction

  function automatic vec_t mk(input logic [15:0] m0, input logic [15:0] x0,
                              input logic [15:0] m1, input logic [15:0] x1,
                              input logic [15:0] m2, input logic [15:0] x2,
                              input logic [15:0] st, input int cyc);
    vec_t v;
    v.mn = {m2, m1, m0};
    v.mx = {x2, x1, x0};
    v.exp_status = st;
    v.exp_cyc = 8'(cyc);
    return v;
  endfunction

  task automatic check_outcome(input string tag, input logic [15:0] exp_st, input int exp_cyc,
                               input logic [2:0][15:0] mn, input logic [2:0][15:0] mx,
                               input int cyc, input logic [15:0] st);
    bit ok;
    ok = (exp_st == 16'h0001);
    check({tag, "_status"}, {32'd0, st}, {32'd0, exp_st});
    check({tag, "_cycles"}, 48'(cyc), 48'(exp_cyc));
    check({tag, "_cfg_valid"}, {47'd0, cfg_valid}, {47'd0, ok});
    check({tag, "_min_flat"}, ucc_min_flat, ok ? mn : 48'd0);
    check({tag, "_max_flat"}, ucc_max_flat, ok ? mx : 48'd0);
    check({tag, "_state"}, {45'd0, dbg_state}, {45'd0, ok ? ST_LOCKED : ST_IDLE});
  endtask

  initial begin
    int cyc;
    logic [15:0] st, rd;
    bit m_ok;
    int m_idx, m_kind, m_cyc;
    logic [2:0][15:0] mn, mx;
    logic [15:0] m_st;

    tbl[0] = mk(16'hE000, 16'hE0FF, 16'hE100, 16'hE1FF, 16'hE200, 16'hE2FF, 16'h0001, LAT_OK);
    tbl[1] = mk(16'hE000, 16'hE0FF, 16'h0130, 16'h0150, 16'hE200, 16'hE2FF, 16'h0012, 2);
`ifdef UCCA_OVERLAP_CHECK_EN
    tbl[2] = mk(16'hE000, 16'hE1FF, 16'hF000, 16'hF0FF, 16'hE100, 16'hE2FF, 16'h0102, 5);
`else
    tbl[2] = mk(16'hE000, 16'hE1FF, 16'hF000, 16'hF0FF, 16'hE100, 16'hE2FF, 16'h0001, 4);
`endif
    tbl[3] = mk(16'hE001, 16'hE0FF, 16'hE100, 16'hE1FF, 16'hE200, 16'hE2FF, 16'h0002, 1);
    tbl[4] = mk(16'hE000, 16'hE000, 16'hE100, 16'hE1FF, 16'hE200, 16'hE2FF, 16'h0002, 1);
    tbl[5] = mk(16'hE000, 16'hE0FF, 16'hE100, 16'hE1FF, 16'h016A, 16'h0200, 16'h0022, 3);
    tbl[6] = mk(16'hE000, 16'hE0FF, 16'hE100, 16'hE1FF, 16'h016C, 16'h0200, 16'h0001, LAT_OK);
    tbl[7] = mk(16'h0000, 16'h013F, 16'hE100, 16'hE1FF, 16'hE200, 16'hE2FF, 16'h0001, LAT_OK);
    tbl[8] = mk(16'h0000, 16'h0140, 16'hE100, 16'hE1FF, 16'hE200, 16'hE2FF, 16'h0002, 1);

    // Reset state
    apply_reset();
    bus_read(OFF_CTRL, rd);  check("rst_status", {32'd0, rd}, 48'd0);
    bus_read(14'd1, rd);     check("rst_min0", {32'd0, rd}, 48'd0);
    bus_read(14'd7, rd);     check("out_of_range_read", {32'd0, rd}, 48'd0);
    check("rst_cfg_valid", {47'd0, cfg_valid}, 48'd0);
    check("rst_lock_viol", {47'd0, lock_viol}, 48'd0);
    check("rst_min_flat", ucc_min_flat, 48'd0);
    check("rst_state", {45'd0, dbg_state}, {45'd0, ST_IDLE});
    bus_write(14'd5, 16'hBEEF);
    check("dout_idle_bus", {32'd0, per_dout}, 48'd0);

    // Directed vector table
    for (int t = 0; t < 9; t++) begin
      apply_reset();
      program_regions(tbl[t].mn, tbl[t].mx);
      run_commit(cyc, st);
      check_outcome($sformatf("vec%0d", t), tbl[t].exp_status, int'(tbl[t].exp_cyc),
                    tbl[t].mn, tbl[t].mx, cyc, st);
    end

    // Write while LOCKED: one-cycle lock_viol, nothing changes
    apply_reset();
    program_regions(tbl[0].mn, tbl[0].mx);
    run_commit(cyc, st);
    bus_write(14'd1, 16'h1234);
    check("lock_viol_pulse", {47'd0, lock_viol}, 48'd1);
    @(posedge clk); #1;
    check("lock_viol_clears", {47'd0, lock_viol}, 48'd0);
    bus_read(14'd1, rd);
    check("locked_min0_kept", {32'd0, rd}, 48'hE000);
    check("locked_out_kept", ucc_min_flat, tbl[0].mn);

    // Writes while busy are dropped and raise no violation
    apply_reset();
    program_regions(tbl[0].mn, tbl[0].mx);
    bus_write(OFF_CTRL, 16'h0001);
    bus_write(14'd1, 16'h0001);
    check("busy_write_no_viol", {47'd0, lock_viol}, 48'd0);
    wait_done(cyc, st);
    check("busy_write_status", {32'd0, st}, 48'h0001);
    check("busy_write_dropped", ucc_min_flat, tbl[0].mn);

    // hw_reset during the second CHECK cycle aborts without error
    apply_reset();
    program_regions(tbl[0].mn, tbl[0].mx);
    bus_write(OFF_CTRL, 16'h0001);
    @(posedge clk); #1;
    hw_reset = 1'b1;
    @(posedge clk); #1;
    hw_reset = 1'b0;
    check("hwrst_state", {45'd0, dbg_state}, {45'd0, ST_IDLE});
    bus_read(OFF_CTRL, rd);  check("hwrst_status", {32'd0, rd}, 48'd0);
    bus_read(14'd3, rd);     check("hwrst_min1_kept", {32'd0, rd}, 48'hE100);
    bus_read(14'd6, rd);     check("hwrst_max2_kept", {32'd0, rd}, 48'hE2FF);
    check("hwrst_cfg_valid", {47'd0, cfg_valid}, 48'd0);
    run_commit(cyc, st);
    check_outcome("hwrst_recommit", 16'h0001, LAT_OK, tbl[0].mn, tbl[0].mx, cyc, st);

    // Asynchronous reset while LOCKED clears outputs without a clock edge
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_cfg_valid", {47'd0, cfg_valid}, 48'd0);
    check("async_rst_min_flat", ucc_min_flat, 48'd0);
    check("async_rst_max_flat", ucc_max_flat, 48'd0);
    check("async_rst_state", {45'd0, dbg_state}, {45'd0, ST_IDLE});
    #1 reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin mdl_min[k] = '0; mdl_max[k] = '0; end
    program_regions(tbl[6].mn, tbl[6].mx);
    run_commit(cyc, st);
    check_outcome("reprogram", 16'h0001, LAT_OK, tbl[6].mn, tbl[6].mx, cyc, st);

    // Randomized commits against the reference model
    for (int t = 0; t < 40; t++) begin
      apply_reset();
      for (int k = 0; k < N; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) begin
          mn[k] = 16'(k * 16'h4000 + 16'h1000 + ($urandom_range(0, 16'h1000) & 16'hFFFE));
          mx[k] = mn[k] + 16'($urandom_range(2, 16'h1000));
        end else if (r < 7) begin
          mn[k] = 16'($urandom_range(0, 16'hF000)) & 16'hFFFE;
          mx[k] = mn[k] + 16'($urandom_range(1, 16'h0FFF));
        end else if (r == 7) begin
          mn[k] = 16'($urandom_range(0, 16'hF000)) & 16'hFFFE;
          mx[k] = mn[k];
        end else if (r == 8) begin
          mn[k] = 16'($urandom_range(0, 16'hF000)) | 16'h0001;
          mx[k] = mn[k] + 16'h0100;
        end else begin
          mn[k] = 16'($urandom_range(0, 16'hFFFF));
          mx[k] = 16'($urandom_range(0, 16'hFFFF));
        end
      end
      program_regions(mn, mx);
      predict(m_ok, m_idx, m_kind, m_cyc);
      m_st = m_ok ? 16'h0001 : 16'(16'h0002 | (m_idx << 4) | (m_kind << 8));
      run_commit(cyc, st);
      check_outcome($sformatf("rand%0d", t), m_st, m_cyc, mn, mx, cyc, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ucca_cfg_ctrl.md
# ucca_cfg_ctrl

Memory-mapped configuration controller for the UCCA region monitors. Software loads per-region min/max bounds into staging registers over the openMSP430 peripheral bus and issues a commit. A sequencer then validates every region one per cycle, and can also check pairwise overlap. On success it publishes the bounds to the `hwmod` `ucc_min_*`/`ucc_max_*` inputs and locks them until power-on reset.

## Interface
Parameters:
- `NUM_REGIONS`, 3: number of UCCA regions (1–8).
- `BASE_ADDR`, 14'h0060: peripheral word address of the CTRL register.
- `META_MIN`, 16'h0140: start of the protected metadata window.
- `META_MAX`, 16'h016A: end of the protected metadata window, inclusive.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `per_en`  in  1: peripheral access strobe.
- `per_we`  in  2: byte write enables; any nonzero value means a word write.
- `per_addr`  in  14: word address.
- `per_din`  in  16: write data.
- `per_dout`  out  16: read data; 0 when the access is not addressed to this block.
- `hw_reset`  in  1: `hwmod` reset output.
- `ucc_min_flat`  out  16*NUM_REGIONS: published lower bounds; region i occupies bits [16i+15:16i].
- `ucc_max_flat`  out  16*NUM_REGIONS: published upper bounds, same packing.
- `cfg_valid`  out  1: bounds are published and locked.
- `lock_viol`  out  1: one-cycle pulse on a write attempt while LOCKED.

## Operation
- Register map (word offset from `BASE_ADDR`):
  - Offset 0 is CTRL/STATUS.
  - Offset 2i+1 is `MIN[i]`; offset 2i+2 is `MAX[i]`.
- STATUS read bits:
  - [0] LOCKED
  - [1] ERROR
  - [2] BUSY
  - [6:4] ERR_IDX
  - [8] ERR_KIND (0 = bounds, 1 = overlap)
- CTRL write: bit0 = COMMIT. A COMMIT write also clears ERROR.
- Staging writes are accepted only in IDLE. Writes in any other state are dropped.
- FSM states: IDLE, CHECK, OVL, PUBLISH, LOCKED.
- IDLE → CHECK on COMMIT. The region counter `idx` is set to 0.
- CHECK, one region per cycle. Region `idx` fails if any of the following holds:
  - `min[0]` = 1
  - `min` ≥ `max` (unsigned compare)
  - [`min`, `max`] intersects [`META_MIN`, `META_MAX`]
- On failure: ERROR=1, ERR_IDX=`idx`, ERR_KIND=0, next state IDLE.
- After `idx` = NUM_REGIONS-1 passes: go to OVL if the overlap check is compiled in, otherwise PUBLISH.
- OVL, one pair (i<j) per cycle, in lexicographic order. A pair overlaps iff `min_i` ≤ `max_j` and `min_j` ≤ `max_i`.
- On overlap: ERROR=1, ERR_IDX=i, ERR_KIND=1, next state IDLE.
- PUBLISH: copy staging to the outputs, set `cfg_valid`, go to LOCKED.
- LOCKED is terminal; only `reset_n` leaves it. Any bus write to the block's range pulses `lock_viol`; the registers stay unchanged.
- `hw_reset` high while in CHECK, OVL or PUBLISH aborts to IDLE. Staging is kept and ERROR is not set. `hw_reset` has no effect in LOCKED or IDLE.

## Timing
- Reset values:
  - All staging registers, `ucc_min_flat`, `ucc_max_flat`: 0.
  - `cfg_valid`=0, `lock_viol`=0, STATUS=0, state IDLE.
- `per_dout` is combinational from the registers. A write lands on the next `clk` edge.
- Commit latency from the COMMIT write edge to `cfg_valid`=1:
  - With the overlap check: NUM_REGIONS + NUM_REGIONS·(NUM_REGIONS-1)/2 + 1 cycles (7 for N=3).
  - Without it: NUM_REGIONS + 1 cycles.
- BUSY=1 in CHECK, OVL and PUBLISH. A COMMIT while BUSY is ignored.
- The outputs change only on the PUBLISH edge; there are no intermediate glitches on the bounds.
- `lock_viol` is registered and asserts the cycle after the offending write.

## Configuration
- `UCCA_OVERLAP_CHECK_EN` defined: the OVL state and pair counters are present, and overlapping regions are rejected.
- Undefined: CHECK goes directly to PUBLISH, overlapping regions are accepted, and ERR_KIND always reads 0.

## Structure
- Shared package `ucca_cfg_pkg` holds:
  - the FSM state encoding,
  - register offsets,
  - STATUS bit positions,
  - the `META_MIN`/`META_MAX` defaults.
- Sub-module `ucca_bound_check`: combinational single-region validator (`min`, `max` → fail). Instantiated once and muxed by `idx`.

## Test plan
- Region0=0xE000..0xE0FF, region1=0xE100..0xE1FF, region2=0xE200..0xE2FF; COMMIT → `cfg_valid`=1 after 7 cycles; outputs match; STATUS=0x0001.
- `MIN[1]`=0x0130, `MAX[1]`=0x0150 → ERROR, ERR_IDX=1, ERR_KIND=0; `cfg_valid` stays 0; state IDLE.
- Region0=0xE000..0xE1FF, region2=0xE100..0xE2FF → overlap error, ERR_IDX=0, ERR_KIND=1. With the macro undefined, the same stimulus locks after 4 cycles.
- After lock, write 0x1234 to `MIN[0]` → `lock_viol` pulses for 1 cycle; `MIN[0]` and the output are unchanged.
- `hw_reset` pulsed on the 2nd CHECK cycle → state IDLE, ERROR=0, staging intact; re-COMMIT succeeds.
- `reset_n` asserted while LOCKED → all outputs 0 immediately, without waiting for a clock edge; reprogramming works.
